// File: rtl/keypad_emulator.sv
// Keypad emulator: answers a 4x4 matrix scanner with active-low row returns for one commanded key,
// running press, optional pseudo-random contact bounce, hold, release bounce and an open gap.
module keypad_emulator #(
    parameter int          BOUNCE_CYCLES = 2000,
    parameter int          GAP_CYCLES    = 20000,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        CLOCK_50,
    input  logic        Reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_key,
    input  logic [23:0] cmd_hold,
    input  logic        cmd_bounce,
    input  logic [3:0]  cols_n,
    output logic [3:0]  rows_n,
    output logic        pressed,
    output logic        busy,
    output logic        done
);

    localparam logic [23:0] BOUNCE_LOAD = 24'(BOUNCE_CYCLES - 1);
    localparam logic [23:0] GAP_LOAD    = 24'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, PB, HOLD, RB, GAP} state_t;

    state_t      state_q;
    logic [23:0] cnt_q;
    logic [5:0]  subCnt_q;
    logic [15:0] lfsr_q;
    logic [23:0] hold_q;
    logic        bounce_q;
    logic [1:0]  row_q;
    logic [1:0]  col_q;
    logic        pressed_q;
    logic        done_q;
    logic [3:0]  rows_q;

    logic [1:0]  keyRow;
    logic [1:0]  keyCol;
    logic        lfsrFb;
    logic        colActive;

    // A zero hold still closes the contact for one clock.
    function automatic logic [23:0] holdLoad(input logic [23:0] h);
        return (h == 24'd0) ? 24'd0 : h - 24'd1;
    endfunction

    always_comb begin
        keyRow = 2'd0;
        keyCol = 2'd0;
        case (cmd_key)
            4'h1: begin keyRow = 2'd0; keyCol = 2'd0; end
            4'h2: begin keyRow = 2'd0; keyCol = 2'd1; end
            4'h3: begin keyRow = 2'd0; keyCol = 2'd2; end
            4'hA: begin keyRow = 2'd0; keyCol = 2'd3; end
            4'h4: begin keyRow = 2'd1; keyCol = 2'd0; end
            4'h5: begin keyRow = 2'd1; keyCol = 2'd1; end
            4'h6: begin keyRow = 2'd1; keyCol = 2'd2; end
            4'hB: begin keyRow = 2'd1; keyCol = 2'd3; end
            4'h7: begin keyRow = 2'd2; keyCol = 2'd0; end
            4'h8: begin keyRow = 2'd2; keyCol = 2'd1; end
            4'h9: begin keyRow = 2'd2; keyCol = 2'd2; end
            4'hC: begin keyRow = 2'd2; keyCol = 2'd3; end
            4'hE: begin keyRow = 2'd3; keyCol = 2'd0; end
            4'h0: begin keyRow = 2'd3; keyCol = 2'd1; end
            4'hF: begin keyRow = 2'd3; keyCol = 2'd2; end
            4'hD: begin keyRow = 2'd3; keyCol = 2'd3; end
            default: begin keyRow = 2'd0; keyCol = 2'd0; end
        endcase
    end

    // Column 0 is cols_n bit 3, so the latched column indexes from the top.
    assign colActive = ~cols_n[2'd3 - col_q];
    assign lfsrFb    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= 24'd0;
            subCnt_q  <= 6'd0;
            lfsr_q    <= LFSR_SEED;
            hold_q    <= 24'd0;
            bounce_q  <= 1'b0;
            row_q     <= 2'd0;
            col_q     <= 2'd0;
            pressed_q <= 1'b0;
            done_q    <= 1'b0;
            rows_q    <= 4'hF;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsrFb};
            done_q <= 1'b0;
            rows_q <= (pressed_q && colActive) ? ~(4'b1000 >> row_q) : 4'hF;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        row_q     <= keyRow;
                        col_q     <= keyCol;
                        hold_q    <= cmd_hold;
                        bounce_q  <= cmd_bounce;
                        pressed_q <= 1'b1;
                        if (cmd_bounce) begin
                            state_q  <= PB;
                            cnt_q    <= BOUNCE_LOAD;
                            subCnt_q <= lfsr_q[5:0];
                        end else begin
                            state_q <= HOLD;
                            cnt_q   <= holdLoad(cmd_hold);
                        end
                    end
                end
                PB, RB: begin
                    if (cnt_q == 24'd0) begin
                        if (state_q == PB) begin
                            state_q   <= HOLD;
                            pressed_q <= 1'b1;
                            cnt_q     <= holdLoad(hold_q);
                        end else begin
                            state_q   <= GAP;
                            pressed_q <= 1'b0;
                            cnt_q     <= GAP_LOAD;
                            done_q    <= (GAP_CYCLES == 1);
                        end
                    end else begin
                        cnt_q <= cnt_q - 24'd1;
                        if (subCnt_q == 6'd0) begin
                            pressed_q <= ~pressed_q;
                            subCnt_q  <= lfsr_q[5:0];
                        end else begin
                            subCnt_q <= subCnt_q - 6'd1;
                        end
                    end
                end
                HOLD: begin
                    if (cnt_q == 24'd0) begin
                        pressed_q <= 1'b0;
                        if (bounce_q) begin
                            state_q  <= RB;
                            cnt_q    <= BOUNCE_LOAD;
                            subCnt_q <= lfsr_q[5:0];
                        end else begin
                            state_q <= GAP;
                            cnt_q   <= GAP_LOAD;
                            done_q  <= (GAP_CYCLES == 1);
                        end
                    end else begin
                        cnt_q <= cnt_q - 24'd1;
                    end
                end
                GAP: begin
                    if (cnt_q == 24'd0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q  <= cnt_q - 24'd1;
                        done_q <= (cnt_q == 24'd1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = ~cmd_ready;
    assign pressed   = pressed_q;
    assign done      = done_q;
    assign rows_n    = rows_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator: runs single commands, logs outputs per cycle
// and compares against hand-derived timing for the configured bounce and gap lengths.
module tb_keypad_emulator;

    localparam int B    = 200;
    localparam int G    = 50;
    localparam int MAXN = 8192;

    logic        CLOCK_50 = 1'b0;
    logic        Reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_key;
    logic [23:0] cmd_hold;
    logic        cmd_bounce;
    logic [3:0]  cols_n;
    logic [3:0]  rows_n;
    logic        pressed;
    logic        busy;
    logic        done;

    logic        pressLog [MAXN];
    logic [3:0]  rowsLog  [MAXN];
    logic        readyLog [MAXN];
    int          doneAt;
    int          doneCount;
    int          total = 0;
    int          bad   = 0;

    keypad_emulator #(
        .BOUNCE_CYCLES(B),
        .GAP_CYCLES   (G),
        .LFSR_SEED    (16'hACE1)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .Reset     (Reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_key   (cmd_key),
        .cmd_hold  (cmd_hold),
        .cmd_bounce(cmd_bounce),
        .cols_n    (cols_n),
        .rows_n    (rows_n),
        .pressed   (pressed),
        .busy      (busy),
        .done      (done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
        end
    endtask

    function automatic int countRows(input int from, input int to, input logic [3:0] val);
        int c = 0;
        for (int i = from; i <= to; i++) if (rowsLog[i] == val) c++;
        return c;
    endfunction

    function automatic int countPressed(input int from, input int to);
        int c = 0;
        for (int i = from; i <= to; i++) if (pressLog[i]) c++;
        return c;
    endfunction

    function automatic int countToggles(input int from, input int to);
        int c = 0;
        for (int i = from + 1; i <= to; i++) if (pressLog[i] != pressLog[i-1]) c++;
        return c;
    endfunction

    // Sample n is taken just after the n-th edge following the accepting edge.
    task automatic applyStimulus(input logic [3:0] key, input logic [23:0] hold, input logic bounce,
                                 input logic [3:0] cols, input int cycles, input int injectFrom,
                                 input int resetAt);
        cols_n     = cols;
        cmd_key    = key;
        cmd_hold   = hold;
        cmd_bounce = bounce;
        cmd_valid  = 1'b1;
        tick();
        cmd_valid = 1'b0;
        doneAt    = -1;
        doneCount = 0;
        for (int n = 0; n < cycles; n++) begin
            pressLog[n] = pressed;
            rowsLog[n]  = rows_n;
            readyLog[n] = cmd_ready;
            if (done) begin
                doneCount++;
                if (doneAt < 0) doneAt = n;
            end
            cmd_valid = (injectFrom >= 0) && (n >= injectFrom) && (n < injectFrom + 5);
            cmd_key   = cmd_valid ? 4'h9 : key;
            Reset     = (n == resetAt);
            tick();
        end
        cmd_valid = 1'b0;
        Reset     = 1'b0;
    endtask

    initial begin
        Reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_key    = 4'h0;
        cmd_hold   = 24'd0;
        cmd_bounce = 1'b0;
        cols_n     = 4'hF;
        tick();
        tick();
        checkOutput("resetRows", int'(rows_n), 15);
        checkOutput("resetPressed", int'(pressed), 0);
        checkOutput("resetReady", int'(cmd_ready), 1);
        checkOutput("resetBusy", int'(busy), 0);
        checkOutput("resetDone", int'(done), 0);
        Reset = 1'b0;
        tick();

        applyStimulus(4'h5, 24'd100, 1'b0, 4'b1011, 160, -1, -1);
        checkOutput("k5RowsLatency", int'(rowsLog[0]), 15);
        checkOutput("k5RowsFirst", int'(rowsLog[1]), 4'b1011);
        checkOutput("k5RowsLast", int'(rowsLog[100]), 4'b1011);
        checkOutput("k5RowsAfter", int'(rowsLog[101]), 15);
        checkOutput("k5RowsCount", countRows(0, 159, 4'b1011), 100);
        checkOutput("k5PressCount", countPressed(0, 159), 100);
        checkOutput("k5DoneAt", doneAt, 100 + G - 1);
        checkOutput("k5DoneCount", doneCount, 1);
        checkOutput("k5ReadyAtDone", int'(readyLog[100 + G - 1]), 0);
        checkOutput("k5ReadyAfterDone", int'(readyLog[100 + G]), 1);

        applyStimulus(4'h5, 24'd20, 1'b0, 4'b0111, 80, -1, -1);
        checkOutput("k5OtherColIdle", countRows(0, 79, 4'hF), 80);

        applyStimulus(4'h5, 24'd20, 1'b0, 4'b0011, 80, -1, -1);
        checkOutput("k5ExtraColBits", countRows(0, 79, 4'b1011), 20);

        applyStimulus(4'hD, 24'd0, 1'b0, 4'b1110, 60, -1, -1);
        checkOutput("kDPressCount", countPressed(0, 59), 1);
        checkOutput("kDRowsCount", countRows(0, 59, 4'b1110), 1);
        checkOutput("kDRowsFirst", int'(rowsLog[1]), 4'b1110);
        checkOutput("kDDoneAt", doneAt, G);

        applyStimulus(4'h0, 24'd5000, 1'b1, 4'b1011, 2*B + 5000 + G + 5, -1, -1);
        checkOutput("k0PressBounce", int'(countToggles(0, B - 1) >= 2), 1);
        checkOutput("k0HoldStable", countPressed(B, B + 5000 - 1), 5000);
        checkOutput("k0RbEntry", int'(pressLog[B + 5000]), 0);
        checkOutput("k0ReleaseBounce", int'(countToggles(B + 5000, 2*B + 5000 - 1) >= 2), 1);
        checkOutput("k0EndOpen", int'(pressLog[2*B + 5000]), 0);
        checkOutput("k0HoldRows", countRows(B + 1, B + 5000, 4'b1110), 5000);
        checkOutput("k0DoneAt", doneAt, 2*B + 5000 + G - 1);
        checkOutput("k0DoneCount", doneCount, 1);

        applyStimulus(4'h1, 24'd60, 1'b0, 4'b0111, 60 + G + 20, 10, -1);
        checkOutput("k1IgnoreRows", countRows(0, 60 + G + 19, 4'b0111), 60);
        checkOutput("k1IgnorePress", countPressed(0, 60 + G + 19), 60);
        checkOutput("k1IgnoreDone", doneCount, 1);
        checkOutput("k1IgnoreReady", int'(readyLog[60 + G + 19]), 1);

        applyStimulus(4'h5, 24'd100, 1'b0, 4'b1011, 200, -1, 10);
        checkOutput("rstPreRows", int'(rowsLog[10]), 4'b1011);
        checkOutput("rstRows", int'(rowsLog[11]), 15);
        checkOutput("rstPressed", int'(pressLog[11]), 0);
        checkOutput("rstReady", int'(readyLog[11]), 1);
        checkOutput("rstNoDone", doneCount, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
